riscv_wb_arbiter: RTL and testbench
===================================

// Module: riscv_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between three result sources:
//   - EXU: 1-cycle ALU results; cannot be back-pressured.
//   - LSU: load data.
//   - MDU: multi-cycle mul/div results.
//  Sits between the execute/memory stages and the register file.
//  The EXU always wins the port; LSU and MDU share what is left, round-robin.
//  Raises stall_o to freeze issue when LSU/MDU are starved, so the EXU slot drains.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive EXU-blocked cycles before stall_o asserts (legal range 1..15)
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_ni       in   1   reset, asynchronous, active-low
//  exu_idx_i    in   5   EXU destination register; 0 = no write this cycle
//  exu_value_i  in   32  EXU result
//  lsu_valid_i  in   1   LSU result pending
//  lsu_idx_i    in   5   LSU destination register
//  lsu_value_i  in   32  LSU load data
//  lsu_ready_o  out  1   LSU result accepted this cycle
//  mdu_valid_i  in   1   MDU result pending
//  mdu_idx_i    in   5   MDU destination register
//  mdu_value_i  in   32  MDU result
//  mdu_ready_o  out  1   MDU result accepted this cycle
//  rf_we_o      out  1   register-file write enable (registered)
//  rf_idx_o     out  5   register-file write index (registered)
//  rf_value_o   out  32  register-file write data (registered)
//  stall_o      out  1   freeze instruction issue (registered state, Moore)
// BEHAVIOUR
//  Reset values:
//   - rf_we_o=0, rf_idx_o=0, rf_value_o=0, stall_o=0.
//   - Round-robin pointer rr_q=0 (LSU preferred); starvation counter cnt_q=0.
//   - While rst_ni=0, lsu_ready_o=0 and mdu_ready_o=0.
//   - Reset mid-transfer drops any un-handshaken result; sources re-present after reset.
//  Handshake (valid/ready):
//   - Transfer occurs when valid and ready are both high in the same cycle.
//   - Source holds valid, idx and value stable until the transfer.
//   - ready is combinational from valid, idx, exu_idx_i and rr_q.
//  Index-0 requests:
//   - A request with idx=0 never uses the port.
//   - Its ready is 1 in the same cycle it is presented, regardless of EXU/rr_q; no write results.
//   - It does not update rr_q or cnt_q.
//  Grant, evaluated each cycle:
//   1. exu_idx_i!=0: EXU owns the port; both LSU and MDU nonzero requests get ready=0.
//   2. Otherwise, if only one of LSU/MDU has a nonzero request, that source gets ready=1.
//   3. Otherwise, if both do, rr_q=0 grants LSU and rr_q=1 grants MDU.
//  Round-robin update:
//   - LSU grant sets rr_q=1; MDU grant sets rr_q=0.
//   - rr_q is unchanged when there is no LSU/MDU grant.
//  Write latency: 1 cycle.
//   - The cycle after a grant: rf_we_o=1 with the winner's idx and value.
//   - Otherwise rf_we_o=0; rf_idx_o and rf_value_o hold their last values.
//  Starvation counter (cnt_q, 4 bits, saturating at 15):
//   - +1 each cycle where exu_idx_i!=0 and at least one LSU/MDU nonzero request is pending.
//   - Cleared in any cycle with an LSU or MDU grant; otherwise held.
//  stall_o = (cnt_q >= STARVE_LIMIT).
//   - Issue freezes, so the EXU presents idx 0 one cycle later and the starved source is granted.
//   - cnt_q clears on that grant; stall_o drops the following cycle.
//  Ordering:
//   - EXU and a pending load/MDU result never target the same rd.
//   - The issue-stage scoreboard guarantees this; the arbiter does no rd compare.
// TESTING
//  T1 Reset: rst_ni=0 with all valid inputs high -> rf_we_o=0, both ready=0, stall_o=0.
//  T2 EXU only: exu_idx_i=5, exu_value_i=0x1234 for 1 cycle -> next cycle rf_we_o=1, rf_idx_o=5, rf_value_o=0x1234.
//  T3 Collision: exu_idx_i=3 and LSU valid idx=7 val=0xAA in the same cycle.
//     -> lsu_ready_o=0; x3 written next cycle.
//     -> With exu_idx_i=0 the following cycle, lsu_ready_o=1 and x7=0xAA is written one cycle later.
//  T4 Fairness: EXU idle; LSU (idx 1) and MDU (idx 2) valid for 4 back-to-back transfers each.
//     -> Grants alternate L,M,L,M,... starting with LSU after reset.
//  T5 Starvation: STARVE_LIMIT=4; EXU writes every cycle and LSU idx=9 is held valid.
//     -> stall_o=1 after 4 blocked cycles.
//     -> Bench drives exu_idx_i=0 next cycle; LSU granted that cycle; stall_o=0 the cycle after.
//  T6 Index 0: EXU idx=4 busy and LSU valid idx=0.
//     -> lsu_ready_o=1 the same cycle; only x4 is written; cnt_q and rr_q unchanged.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: EXU always wins, LSU/MDU share leftovers round-robin.
// 1-cycle write latency; LSU/MDU back-pressured via ready, EXU never; stall_o raised on starvation.
module riscv_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  exu_idx_i,
    input  logic [31:0] exu_value_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_idx_i,
    input  logic [31:0] lsu_value_i,
    output logic        lsu_ready_o,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_idx_i,
    input  logic [31:0] mdu_value_i,
    output logic        mdu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_idx_o,
    output logic [31:0] rf_value_o,
    output logic        stall_o
);

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] value;
    } wb_t;

    logic       w_exu_busy;
    logic       w_lsu_req;
    logic       w_mdu_req;
    logic       w_lsu_zero;
    logic       w_mdu_zero;
    logic       w_lsu_gnt;
    logic       w_mdu_gnt;
    logic       w_pending;
    wb_t        w_sel;

    logic       r_rr;
    logic [3:0] r_cnt;
    logic       r_we;
    wb_t        r_wb;

    assign w_exu_busy = (exu_idx_i != 5'd0);
    assign w_lsu_req  = lsu_valid_i && (lsu_idx_i != 5'd0);
    assign w_mdu_req  = mdu_valid_i && (mdu_idx_i != 5'd0);
    assign w_lsu_zero = lsu_valid_i && (lsu_idx_i == 5'd0);
    assign w_mdu_zero = mdu_valid_i && (mdu_idx_i == 5'd0);
    assign w_pending  = w_lsu_req || w_mdu_req;

    // r_rr only breaks ties; a lone requester wins regardless of it
    assign w_lsu_gnt = !w_exu_busy && w_lsu_req && (!w_mdu_req || !r_rr);
    assign w_mdu_gnt = !w_exu_busy && w_mdu_req && (!w_lsu_req ||  r_rr);

    // Index-0 results are discarded on the spot, so they are acked without a grant
    assign lsu_ready_o = rst_ni && (w_lsu_zero || w_lsu_gnt);
    assign mdu_ready_o = rst_ni && (w_mdu_zero || w_mdu_gnt);

    always_comb begin
        w_sel = '{idx: mdu_idx_i, value: mdu_value_i};
        if (w_exu_busy) begin
            w_sel = '{idx: exu_idx_i, value: exu_value_i};
        end else if (w_lsu_gnt) begin
            w_sel = '{idx: lsu_idx_i, value: lsu_value_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we  <= 1'b0;
            r_wb  <= '0;
            r_rr  <= 1'b0;
            r_cnt <= 4'd0;
        end else begin
            r_we <= w_exu_busy || w_lsu_gnt || w_mdu_gnt;
            if (w_exu_busy || w_lsu_gnt || w_mdu_gnt) begin
                r_wb <= w_sel;
            end

            if (w_lsu_gnt) begin
                r_rr <= 1'b1;
            end else if (w_mdu_gnt) begin
                r_rr <= 1'b0;
            end

            if (w_lsu_gnt || w_mdu_gnt) begin
                r_cnt <= 4'd0;
            end else if (w_exu_busy && w_pending && (r_cnt != 4'hF)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign rf_we_o    = r_we;
    assign rf_idx_o   = r_wb.idx;
    assign rf_value_o = r_wb.value;
    assign stall_o    = ({28'd0, r_cnt} >= STARVE_LIMIT);

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic [4:0]  exu_idx_i;
    logic [31:0] exu_value_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_idx_i;
    logic [31:0] lsu_value_i;
    logic        lsu_ready_o;
    logic        mdu_valid_i;
    logic [4:0]  mdu_idx_i;
    logic [31:0] mdu_value_i;
    logic        mdu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_idx_o;
    logic [31:0] rf_value_o;
    logic        stall_o;

    riscv_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .exu_idx_i   (exu_idx_i),
        .exu_value_i (exu_value_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_idx_i   (lsu_idx_i),
        .lsu_value_i (lsu_value_i),
        .lsu_ready_o (lsu_ready_o),
        .mdu_valid_i (mdu_valid_i),
        .mdu_idx_i   (mdu_idx_i),
        .mdu_value_i (mdu_value_i),
        .mdu_ready_o (mdu_ready_o),
        .rf_we_o     (rf_we_o),
        .rf_idx_o    (rf_idx_o),
        .rf_value_o  (rf_value_o),
        .stall_o     (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // readies and stall sampled mid-cycle, before the edge that consumes the inputs
    logic s_lrdy, s_mrdy, s_stall;

    // reference model state
    int          m_rr, m_cnt;
    bit          m_we;
    logic [4:0]  m_idx;
    logic [31:0] m_val;

    typedef struct {
        logic [4:0]  ei;
        logic [31:0] ev;
        logic        lv;
        logic [4:0]  li;
        logic [31:0] lval;
        logic        mv;
        logic [4:0]  mi;
        logic [31:0] mval;
        logic        e_lrdy;
        logic        e_mrdy;
        logic        e_we;
        logic [4:0]  e_idx;
        logic [31:0] e_val;
        logic        e_stall;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [4:0] ei, input logic [31:0] ev,
                        input logic lv, input logic [4:0] li, input logic [31:0] lval,
                        input logic mv, input logic [4:0] mi, input logic [31:0] mval);
        @(negedge clk_i);
        exu_idx_i   = ei;
        exu_value_i = ev;
        lsu_valid_i = lv;
        lsu_idx_i   = li;
        lsu_value_i = lval;
        mdu_valid_i = mv;
        mdu_idx_i   = mi;
        mdu_value_i = mval;
        #1;
        s_lrdy  = lsu_ready_o;
        s_mrdy  = mdu_ready_o;
        s_stall = stall_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        exu_idx_i = 5'd0; exu_value_i = 32'd0;
        lsu_valid_i = 1'b0; lsu_idx_i = 5'd0; lsu_value_i = 32'd0;
        mdu_valid_i = 1'b0; mdu_idx_i = 5'd0; mdu_value_i = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_rr = 0; m_cnt = 0; m_we = 0; m_idx = 5'd0; m_val = 32'd0;
    endtask

    // Port owner decided from the priority rules: 0 none, 1 EXU, 2 LSU, 3 MDU
    task automatic model_step(input logic [4:0] ei, input logic [31:0] ev,
                              input logic lv, input logic [4:0] li, input logic [31:0] lval,
                              input logic mv, input logic [4:0] mi, input logic [31:0] mval,
                              output logic el, output logic em);
        int  owner;
        bit  lq, mq;
        lq = lv && (li != 0);
        mq = mv && (mi != 0);
        if (ei != 0)        owner = 1;
        else if (lq && mq)  owner = (m_rr == 0) ? 2 : 3;
        else if (lq)        owner = 2;
        else if (mq)        owner = 3;
        else                owner = 0;
        el = (lv && li == 0) || owner == 2;
        em = (mv && mi == 0) || owner == 3;
        m_we = (owner != 0);
        case (owner)
            1: begin m_idx = ei; m_val = ev;   end
            2: begin m_idx = li; m_val = lval; m_rr = 1; end
            3: begin m_idx = mi; m_val = mval; m_rr = 0; end
            default: ;
        endcase
        if (owner == 2 || owner == 3) m_cnt = 0;
        else if (owner == 1 && (lq || mq) && m_cnt < 15) m_cnt = m_cnt + 1;
    endtask

    initial begin
        logic        el, em;
        logic [4:0]  ei, rl_i, rm_i;
        logic [31:0] ev, rl_d, rm_d, lval, mval;
        logic        rl_v, rm_v;

        tbl[0] = '{5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0};
        tbl[1] = '{5'd3, 32'h33,   1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd3, 32'h33,   1'b0};
        tbl[2] = '{5'd0, 32'h0,    1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd7, 32'hAA,   1'b0};
        tbl[3] = '{5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd7, 32'hAA,   1'b0};
        tbl[4] = '{5'd0, 32'h0,    1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22,   1'b0};
        tbl[5] = '{5'd0, 32'h0,    1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd1, 32'h11,   1'b0};
        tbl[6] = '{5'd4, 32'h44,   1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd4, 32'h44,   1'b0};
        tbl[7] = '{5'd0, 32'h0,    1'b1, 5'd3, 32'h66, 1'b1, 5'd4, 32'h77, 1'b0, 1'b1, 1'b1, 5'd4, 32'h77,   1'b0};
        tbl[8] = '{5'd0, 32'h0,    1'b1, 5'd3, 32'h66, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h66,   1'b0};
        tbl[9] = '{5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h99, 1'b0, 1'b1, 1'b0, 5'd3, 32'h66,   1'b0};

        // Reset held with every request active, including an index-0 one
        rst_ni = 1'b0;
        exu_idx_i = 5'd6; exu_value_i = 32'hDEAD;
        lsu_valid_i = 1'b1; lsu_idx_i = 5'd5; lsu_value_i = 32'h5;
        mdu_valid_i = 1'b1; mdu_idx_i = 5'd0; mdu_value_i = 32'h6;
        #12;
        chk("rst_we",    rf_we_o,     1'b0);
        chk("rst_idx",   rf_idx_o,    5'd0);
        chk("rst_val",   rf_value_o,  32'd0);
        chk("rst_lrdy",  lsu_ready_o, 1'b0);
        chk("rst_mrdy",  mdu_ready_o, 1'b0);
        chk("rst_stall", stall_o,     1'b0);

        do_reset();
        foreach (tbl[i]) begin
            tick(tbl[i].ei, tbl[i].ev, tbl[i].lv, tbl[i].li, tbl[i].lval,
                 tbl[i].mv, tbl[i].mi, tbl[i].mval);
            chk($sformatf("tbl%0d_lrdy", i),  s_lrdy,     tbl[i].e_lrdy);
            chk($sformatf("tbl%0d_mrdy", i),  s_mrdy,     tbl[i].e_mrdy);
            chk($sformatf("tbl%0d_we", i),    rf_we_o,    tbl[i].e_we);
            chk($sformatf("tbl%0d_idx", i),   rf_idx_o,   tbl[i].e_idx);
            chk($sformatf("tbl%0d_val", i),   rf_value_o, tbl[i].e_val);
            chk($sformatf("tbl%0d_stall", i), stall_o,    tbl[i].e_stall);
        end

        // Fairness: both sources always pending, LSU first after reset
        do_reset();
        lval = 32'h100;
        mval = 32'h200;
        for (int k = 0; k < 8; k++) begin
            tick(5'd0, 32'd0, 1'b1, 5'd1, lval, 1'b1, 5'd2, mval);
            chk($sformatf("rr%0d_lrdy", k), s_lrdy, (k % 2 == 0));
            chk($sformatf("rr%0d_mrdy", k), s_mrdy, (k % 2 == 1));
            chk($sformatf("rr%0d_idx", k),  rf_idx_o, (k % 2 == 0) ? 5'd1 : 5'd2);
            chk($sformatf("rr%0d_val", k),  rf_value_o, (k % 2 == 0) ? lval : mval);
            if (k % 2 == 0) lval = lval + 1;
            else            mval = mval + 1;
        end

        // Starvation: EXU busy every cycle while LSU x9 waits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(5'(10 + i), 32'(i), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
            chk($sformatf("stv%0d_lrdy", i), s_lrdy, 1'b0);
            chk($sformatf("stv%0d_stall", i), stall_o, (i == 3));
        end
        tick(5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        chk("stv_rel_lrdy",   s_lrdy,     1'b1);
        chk("stv_rel_stall",  s_stall,    1'b1);
        chk("stv_rel_we",     rf_we_o,    1'b1);
        chk("stv_rel_idx",    rf_idx_o,   5'd9);
        chk("stv_rel_val",    rf_value_o, 32'h99);
        chk("stv_after_stall", stall_o,   1'b0);

        // Counter must saturate, not wrap, under long starvation
        for (int i = 0; i < 20; i++) begin
            tick(5'd12, 32'hC0 + 32'(i), 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 32'd0);
            chk($sformatf("sat%0d_stall", i), stall_o, (i >= 3));
        end

        // Asynchronous reset clears outputs immediately
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("arst_stall", stall_o,     1'b0);
        chk("arst_we",    rf_we_o,     1'b0);
        chk("arst_lrdy",  lsu_ready_o, 1'b0);

        // Random traffic against the reference model
        do_reset();
        rl_v = 1'b0; rl_i = 5'd0; rl_d = 32'd0;
        rm_v = 1'b0; rm_i = 5'd0; rm_d = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            ei = ($urandom_range(0, 9) < 4) ? 5'($urandom_range(1, 31)) : 5'd0;
            ev = $urandom;
            if (!rl_v && $urandom_range(0, 1) == 1) begin
                rl_v = 1'b1;
                rl_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                rl_d = $urandom;
            end
            if (!rm_v && $urandom_range(0, 2) == 0) begin
                rm_v = 1'b1;
                rm_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                rm_d = $urandom;
            end
            model_step(ei, ev, rl_v, rl_i, rl_d, rm_v, rm_i, rm_d, el, em);
            tick(ei, ev, rl_v, rl_i, rl_d, rm_v, rm_i, rm_d);
            chk("rnd_lrdy",  s_lrdy,     el);
            chk("rnd_mrdy",  s_mrdy,     em);
            chk("rnd_we",    rf_we_o,    m_we);
            chk("rnd_idx",   rf_idx_o,   m_idx);
            chk("rnd_val",   rf_value_o, m_val);
            chk("rnd_stall", stall_o,    (m_cnt >= 4));
            if (el) rl_v = 1'b0;
            if (em) rm_v = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
